// File: rtl/crash_avoid_drive.sv
// Two-channel motor driver with a crash-avoidance sequence: FWD, then on an obstacle
// STOP -> REV -> TURN -> FWD (or STOP again if the obstacle persists).
module crash_avoid_drive #(
  parameter int unsigned PWM_PERIOD  = 100000,
  parameter int unsigned DUTY_FWD    = 70000,
  parameter int unsigned DUTY_REV    = 50000,
  parameter int unsigned DUTY_TURN   = 50000,
  parameter int unsigned STOP_CYCLES = 10000000,
  parameter int unsigned REV_CYCLES  = 50000000,
  parameter int unsigned TURN_CYCLES = 40000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       isCrash,
  output logic       pwmLeft,
  output logic       pwmRight,
  output logic       dirLeft,
  output logic       dirRight,
  output logic [2:0] state
);

  localparam int unsigned MAX_A   = (STOP_CYCLES > REV_CYCLES) ? STOP_CYCLES : REV_CYCLES;
  localparam int unsigned MAX_CYC = (MAX_A > TURN_CYCLES) ? MAX_A : TURN_CYCLES;
  localparam int unsigned TW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int unsigned CW      = (PWM_PERIOD > 1) ? $clog2(PWM_PERIOD) : 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    STOP = 3'd2,
    REV  = 3'd3,
    TURN = 3'd4
  } driveState_t;

  driveState_t     curState, nextState;
  logic [TW-1:0]   timer, nextTimer;
  logic [CW-1:0]   pwmCnt, nextCnt;
  logic [31:0]     nextDuty;
  logic            nextDirL, nextDirR;
  logic            sync1, crashS;

  always_comb begin
    nextState = curState;
    if (!enable) begin
      nextState = IDLE;
    end else begin
      case (curState)
        IDLE: nextState = FWD;
        FWD:  if (crashS) nextState = STOP;
        STOP: if (timer == '0) nextState = REV;
        REV:  if (timer == '0) nextState = TURN;
        TURN: if (timer == '0) nextState = crashS ? STOP : FWD;
        default: nextState = IDLE;
      endcase
    end
  end

  // Timer and PWM counter restart on every state change so each state's
  // duration and PWM phase are measured from its own entry edge.
  always_comb begin
    nextTimer = timer;
    nextCnt   = pwmCnt;
    if (nextState != curState) begin
      nextCnt = '0;
      case (nextState)
        STOP:    nextTimer = TW'(STOP_CYCLES - 1);
        REV:     nextTimer = TW'(REV_CYCLES - 1);
        TURN:    nextTimer = TW'(TURN_CYCLES - 1);
        default: nextTimer = '0;
      endcase
    end else begin
      if (timer != '0) nextTimer = timer - 1'b1;
      if (32'(pwmCnt) >= PWM_PERIOD - 1) nextCnt = '0;
      else nextCnt = CW'(pwmCnt + 1'b1);
    end
  end

  always_comb begin
    nextDuty = '0;
    nextDirL = 1'b1;
    nextDirR = 1'b1;
    case (nextState)
      FWD:  nextDuty = DUTY_FWD;
      REV: begin
        nextDuty = DUTY_REV;
        nextDirL = 1'b0;
        nextDirR = 1'b0;
      end
      TURN: begin
        nextDuty = DUTY_TURN;
        nextDirR = 1'b0;
      end
      default: nextDuty = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= IDLE;
      timer    <= '0;
      pwmCnt   <= '0;
      sync1    <= 1'b0;
      crashS   <= 1'b0;
      pwmLeft  <= 1'b0;
      pwmRight <= 1'b0;
      dirLeft  <= 1'b1;
      dirRight <= 1'b1;
    end else begin
      sync1    <= isCrash;
      crashS   <= sync1;
      curState <= nextState;
      timer    <= nextTimer;
      pwmCnt   <= nextCnt;
      pwmLeft  <= (32'(nextCnt) < nextDuty);
      pwmRight <= (32'(nextCnt) < nextDuty);
      dirLeft  <= nextDirL;
      dirRight <= nextDirR;
    end
  end

  assign state = curState;

endmodule
